fcvt_f2i_ctrl: RTL and testbench

Sequencer and two-requester round-robin arbiter for the shared float-to-integer converter. It accepts conversion requests from requester 0 (core issue path) and requester 1 (wishbone/CSR path), and resolves dynamic rounding mode. It drives the combinational converter from registered operands, captures the result and exceptions, and returns a tagged response. It also accumulates sticky fflags.

---
 rtl/fcvt_f2i_ctrl_if.sv | 58 +++++
 rtl/fcvt_f2i_ctrl.sv | 109 ++++++++++
 tb/tb_fcvt_f2i_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fcvt_f2i_ctrl_if.sv
// Request/response/converter bundle for the float-to-int sequencer.
// slave = controller side, master = requesters, response consumer and converter.
interface fcvt_f2i_ctrl_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24,
  parameter int INT_WIDTH  = 32
);
  localparam int NUM_W = EXP_WIDTH + MANT_WIDTH;

  logic             req0_valid;
  logic             req0_ready;
  logic [NUM_W-1:0] req0_num;
  logic [2:0]       req0_rm;
  logic             req0_signed;

  logic             req1_valid;
  logic             req1_ready;
  logic [NUM_W-1:0] req1_num;
  logic [2:0]       req1_rm;
  logic             req1_signed;

  logic [2:0]       frm_i;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [INT_WIDTH-1:0] rsp_data;
  logic [4:0]           rsp_exc;
  logic                 rsp_illegal;

  logic       fflags_clr;
  logic [4:0] fflags_o;
  logic       busy;

  logic [NUM_W-1:0]     cvt_num;
  logic [2:0]           cvt_round_mode;
  logic                 cvt_signed_out;
  logic [INT_WIDTH-1:0] cvt_out;
  logic [4:0]           cvt_exc;

  modport slave (
    input  req0_valid, req0_num, req0_rm, req0_signed,
    input  req1_valid, req1_num, req1_rm, req1_signed,
    input  frm_i, rsp_ready, fflags_clr, cvt_out, cvt_exc,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_exc, rsp_illegal,
    output fflags_o, busy, cvt_num, cvt_round_mode, cvt_signed_out
  );

  modport master (
    output req0_valid, req0_num, req0_rm, req0_signed,
    output req1_valid, req1_num, req1_rm, req1_signed,
    output frm_i, rsp_ready, fflags_clr, cvt_out, cvt_exc,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_exc, rsp_illegal,
    input  fflags_o, busy, cvt_num, cvt_round_mode, cvt_signed_out
  );
endinterface

// File: rtl/fcvt_f2i_ctrl.sv
// Round-robin sequencer for a shared float-to-int converter; response 2 cycles after grant, 1 op / 3 cycles.
// Backpressure: response held stable while rsp_ready is low; no requester sees ready outside IDLE.
module fcvt_f2i_ctrl #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24,
  parameter int INT_WIDTH  = 32
) (
  input logic            clk,
  input logic            rst_l,
  fcvt_f2i_ctrl_if.slave bus
);
  localparam int NUM_W = EXP_WIDTH + MANT_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic             gnt_any, gnt_id, gnt_fire, gnt_signed, illegal, last_grant;
  logic [NUM_W-1:0] gnt_num;
  logic [2:0]       gnt_rm, rm_res;

  logic [NUM_W-1:0]     cvt_num_q;
  logic [2:0]           cvt_rm_q;
  logic                 cvt_signed_q;
  logic                 rsp_id_q, rsp_illegal_q;
  logic [INT_WIDTH-1:0] rsp_data_q;
  logic [4:0]           rsp_exc_q, fflags_q, fflags_nxt;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    gnt_any    = bus.req0_valid | bus.req1_valid;
    gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    gnt_num    = gnt_id ? bus.req1_num    : bus.req0_num;
    gnt_rm     = gnt_id ? bus.req1_rm     : bus.req0_rm;
    gnt_signed = gnt_id ? bus.req1_signed : bus.req0_signed;
    rm_res     = (gnt_rm == 3'b111) ? bus.frm_i : gnt_rm;
    illegal    = (rm_res == 3'b101) || (rm_res == 3'b110);
    gnt_fire   = (state == IDLE) && gnt_any;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = illegal ? RESP : CONV;
      CONV:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by reset so every output reads 0 while rst_l is low.
  always_comb begin
    bus.req0_ready = rst_l & gnt_fire & ~gnt_id;
    bus.req1_ready = rst_l & gnt_fire & gnt_id;
    bus.rsp_valid  = (state == RESP);
    bus.busy       = (state != IDLE);
  end

  // Clear is applied before the capture OR, so a coinciding capture wins.
  always_comb begin
    fflags_nxt = (bus.fflags_clr ? 5'b0 : fflags_q) | ((state == CONV) ? bus.cvt_exc : 5'b0);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_grant    <= 1'b1;
      cvt_num_q     <= '0;
      cvt_rm_q      <= 3'b0;
      cvt_signed_q  <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_exc_q     <= 5'b0;
      fflags_q      <= 5'b0;
    end else begin
      if (gnt_fire) begin
        last_grant    <= gnt_id;
        rsp_id_q      <= gnt_id;
        rsp_illegal_q <= illegal;
        if (illegal) begin
          rsp_data_q <= '0;
          rsp_exc_q  <= 5'b0;
        end else begin
          cvt_num_q    <= gnt_num;
          cvt_rm_q     <= rm_res;
          cvt_signed_q <= gnt_signed;
        end
      end
      if (state == CONV) begin
        rsp_data_q <= bus.cvt_out;
        rsp_exc_q  <= bus.cvt_exc;
      end
      fflags_q <= fflags_nxt;
    end
  end

  assign bus.cvt_num        = cvt_num_q;
  assign bus.cvt_round_mode = cvt_rm_q;
  assign bus.cvt_signed_out = cvt_signed_q;
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_exc        = rsp_exc_q;
  assign bus.rsp_illegal    = rsp_illegal_q;
  assign bus.fflags_o       = fflags_q;
endmodule

// File: tb/tb_fcvt_f2i_ctrl.sv
// Directed bench for fcvt_f2i_ctrl with a table-driven converter stub for the operands used.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fcvt_f2i_ctrl;
  logic clk;
  logic rst_l;
  int   n_chk;
  int   n_pass;

  fcvt_f2i_ctrl_if #(.EXP_WIDTH(8), .MANT_WIDTH(24), .INT_WIDTH(32)) bus ();

  fcvt_f2i_ctrl #(.EXP_WIDTH(8), .MANT_WIDTH(24), .INT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed conversions for the operands this bench issues.
  logic [31:0] stub_out;
  logic [4:0]  stub_exc;
  always_comb begin
    stub_out = 32'hBAD0_0000;
    stub_exc = 5'b0;
    case (bus.cvt_num)
      32'h40490FDB: begin stub_out = (bus.cvt_round_mode == 3'b011) ? 32'd4 : 32'd3; stub_exc = 5'b00001; end
      32'hBFC00000: begin
        stub_out = (bus.cvt_round_mode inside {3'b000, 3'b010, 3'b100}) ? 32'hFFFFFFFE : 32'hFFFFFFFF;
        stub_exc = 5'b00001;
      end
      32'h7FC00000: begin stub_out = bus.cvt_signed_out ? 32'h7FFFFFFF : 32'hFFFFFFFF; stub_exc = 5'b10000; end
      32'h3F800000: stub_out = 32'd1;
      32'h40000000: stub_out = 32'd2;
      32'h40400000: stub_out = 32'd3;
      default: ;
    endcase
  end
  assign bus.cvt_out = stub_out;
  assign bus.cvt_exc = stub_exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ctl_vec();
    return 32'({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_illegal,
                bus.cvt_signed_out, bus.cvt_round_mode, bus.rsp_exc, bus.fflags_o});
  endfunction

  // Returns the granted index (-1 on timeout) and how many cycles it took.
  task automatic wait_grant(output int gid, output int waited);
    gid = -1;
    waited = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        gid = bus.req1_ready ? 1 : 0;
        waited = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gid, w, last_g, eg, cnt0, cnt1, seen;
    n_chk = 0; n_pass = 0;
    rst_l = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_num = 32'h3F800000; bus.req0_rm = 3'b000; bus.req0_signed = 1'b1;
    bus.req1_valid = 1'b0; bus.req1_num = 32'h40000000; bus.req1_rm = 3'b000; bus.req1_signed = 1'b1;
    bus.frm_i = 3'b000; bus.rsp_ready = 1'b0; bus.fflags_clr = 1'b0;
    last_g = 1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ctl", ctl_vec(), 32'd0);
    check("rst_data", bus.rsp_data, 32'd0);
    check("rst_cvt_num", bus.cvt_num, 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst_l = 1'b1;
    @(negedge clk);

    // Single conversion
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_num = 32'h40490FDB; bus.req0_rm = 3'b000; bus.req0_signed = 1'b1;
    wait_grant(gid, w);
    check("t1_grant", 32'(gid), 32'd0);
    last_g = 0;
    @(negedge clk); bus.req0_valid = 1'b0; #1;
    check("t1_cvt_num", bus.cvt_num, 32'h40490FDB);
    check("t1_conv_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); #1;
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("t1_rsp_data", bus.rsp_data, 32'd3);
    check("t1_rsp_exc", 32'(bus.rsp_exc), 32'h01);
    check("t1_fflags", 32'(bus.fflags_o), 32'h01);
    @(negedge clk); #1;
    check("t1_idle", 32'({bus.rsp_valid, bus.busy}), 32'd0);

    // Tie fairness with both requesters continuously valid
    bus.req0_valid = 1'b1; bus.req0_num = 32'h3F800000; bus.req0_rm = 3'b000;
    bus.req1_valid = 1'b1; bus.req1_num = 32'h40000000; bus.req1_rm = 3'b000;
    cnt0 = 0; cnt1 = 0;
    for (int t = 0; t < 8; t++) begin
      eg = (last_g == 0) ? 1 : 0;
      wait_grant(gid, w);
      check("t2_grant", 32'(gid), 32'(eg));
      check("t2_tput", 32'(w), 32'd0);
      if (gid == 0) cnt0++;
      else if (gid == 1) cnt1++;
      last_g = eg;
      @(negedge clk); @(negedge clk); #1;
      check("t2_rsp_id", 32'(bus.rsp_id), 32'(eg));
      check("t2_rsp_data", bus.rsp_data, (eg == 1) ? 32'd2 : 32'd1);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("t2_cnt0", 32'(cnt0), 32'd4);
    check("t2_cnt1", 32'(cnt1), 32'd4);

    // Dynamic rounding mode sampled in the grant cycle
    bus.req1_valid = 1'b1; bus.req1_num = 32'hBFC00000; bus.req1_rm = 3'b111; bus.frm_i = 3'b010;
    wait_grant(gid, w);
    check("t3_grant", 32'(gid), 32'd1);
    last_g = 1;
    @(negedge clk); bus.req1_valid = 1'b0; bus.frm_i = 3'b001; #1;
    check("t3_cvt_rm", 32'(bus.cvt_round_mode), 32'd2);
    @(negedge clk); #1;
    check("t3_rsp_data", bus.rsp_data, 32'hFFFFFFFE);
    check("t3_rsp_id", 32'(bus.rsp_id), 32'd1);
    @(negedge clk);

    // Illegal via frm_i: no CONV cycle, flags untouched, converter operands retained
    bus.req0_valid = 1'b1; bus.req0_num = 32'h40490FDB; bus.req0_rm = 3'b111; bus.frm_i = 3'b101;
    wait_grant(gid, w);
    check("t3i_grant", 32'(gid), 32'd0);
    last_g = 0;
    @(negedge clk); bus.req0_valid = 1'b0; bus.frm_i = 3'b000; #1;
    check("t3i_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t3i_illegal", 32'(bus.rsp_illegal), 32'd1);
    check("t3i_data_exc", bus.rsp_data | 32'(bus.rsp_exc), 32'd0);
    check("t3i_fflags", 32'(bus.fflags_o), 32'h01);
    check("t3i_cvt_num", bus.cvt_num, 32'hBFC00000);
    @(negedge clk);

    // Illegal static rm 110 on requester 1
    bus.req1_valid = 1'b1; bus.req1_num = 32'h3F800000; bus.req1_rm = 3'b110;
    wait_grant(gid, w);
    check("t3j_grant", 32'(gid), 32'd1);
    last_g = 1;
    @(negedge clk); bus.req1_valid = 1'b0; #1;
    check("t3j_illegal", 32'({bus.rsp_valid, bus.rsp_illegal, bus.rsp_id}), 32'b111);
    @(negedge clk);

    // Backpressure
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_num = 32'h40400000; bus.req0_rm = 3'b000;
    bus.req1_rm = 3'b000; bus.req1_num = 32'h40000000;
    wait_grant(gid, w);
    check("t4_grant", 32'(gid), 32'd0);
    last_g = 0;
    @(negedge clk); bus.req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_hold_ctl", 32'({bus.rsp_valid, bus.rsp_id, bus.busy, bus.req0_ready, bus.req1_ready}), 32'b10100);
      check("t4_hold_data", bus.rsp_data, 32'd3);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1; #1;
    check("t4_still_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    wait_grant(gid, w);
    check("t4_regrant", 32'(gid), 32'd1);
    check("t4_regrant_wait", 32'(w), 32'd0);
    last_g = 1;
    @(negedge clk); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    check("t4_rsp2", 32'({bus.rsp_valid, bus.rsp_id}), 32'b11);
    check("t4_rsp2_data", bus.rsp_data, 32'd2);
    @(negedge clk);

    // Invalid operand with clear coinciding with capture
    bus.req0_valid = 1'b1; bus.req0_num = 32'h7FC00000; bus.req0_rm = 3'b000; bus.req0_signed = 1'b1;
    wait_grant(gid, w);
    check("t5_grant", 32'(gid), 32'd0);
    last_g = 0;
    @(negedge clk); bus.req0_valid = 1'b0; bus.fflags_clr = 1'b1;
    @(negedge clk); bus.fflags_clr = 1'b0; #1;
    check("t5_fflags", 32'(bus.fflags_o), 32'h10);
    check("t5_rsp_exc", 32'(bus.rsp_exc), 32'h10);
    check("t5_rsp_data", bus.rsp_data, 32'h7FFFFFFF);
    @(negedge clk); bus.fflags_clr = 1'b1;
    @(negedge clk); bus.fflags_clr = 1'b0; #1;
    check("t5_clr", 32'(bus.fflags_o), 32'd0);

    // Reset during CONV
    bus.req0_valid = 1'b1; bus.req0_num = 32'h3F800000;
    wait_grant(gid, w);
    check("t6_grant", 32'(gid), 32'd0);
    @(negedge clk); bus.req1_valid = 1'b1; #1;
    rst_l = 1'b0; #1;
    check("t6_rst_ctl", ctl_vec(), 32'd0);
    check("t6_rst_data", bus.rsp_data, 32'd0);
    check("t6_rst_cvt_num", bus.cvt_num, 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_l = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.rsp_valid || bus.busy) seen++;
      @(negedge clk);
    end
    check("t6_no_rsp", 32'(seen), 32'd0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    wait_grant(gid, w);
    check("t6_tie_after_rst", 32'(gid), 32'd0);
    @(negedge clk); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    check("t6_rsp", 32'({bus.rsp_valid, bus.rsp_id}), 32'b10);
    check("t6_rsp_data", bus.rsp_data, 32'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
